ms_channel_arbiter: RTL

//  Round-robin arbiter sharing one blocking master-slave channel among N_MASTERS masters.

---
 rtl/ms_channel_arbiter_pkg.sv | 20 ++
 rtl/ms_channel_arbiter_if.sv | 32 +++
 rtl/ms_channel_arbiter_rr_pick.sv | 37 +++
 rtl/ms_channel_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ms_channel_arbiter_pkg.sv
// rtl/ms_channel_arbiter_pkg.sv - shared types and constants for the master-slave channel arbiter
//   ArbSections : arbiter phase enumeration (idle, offer, done)
//   ARB_*       : 2-bit state constants used by the state register
//   MS_ARB_MAX_MASTERS / MS_ARB_CNT_W : supported master count and wait-counter width
package ms_arbiter_types;

  typedef enum logic [1:0] {
    arb_idle  = 2'd0,
    arb_offer = 2'd1,
    arb_done  = 2'd2
  } ArbSections;

  localparam logic [1:0] ARB_IDLE  = arb_idle;
  localparam logic [1:0] ARB_OFFER = arb_offer;
  localparam logic [1:0] ARB_DONE  = arb_done;

  localparam int MS_ARB_MAX_MASTERS = 16;
  localparam int MS_ARB_CNT_W       = 8;

endpackage

// File: rtl/ms_channel_arbiter_if.sv
// rtl/ms_channel_arbiter_if.sv - bundle of master request, slave channel and status signals
//   m_data/m_sync/m_notify : upstream per-master payload, request and completion pulse
//   s_out/s_out_sync/s_ready : downstream payload, valid and accept
//   grant_id/busy/err      : arbiter status
//   modport master : arbiter view (it drives the downstream channel)
//   modport slave  : environment view (masters and slave around the arbiter)
interface ms_channel_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32
);
  localparam int IDX_W = $clog2(N_MASTERS);

  logic [N_MASTERS*DATA_W-1:0] m_data;
  logic [N_MASTERS-1:0]        m_sync;
  logic [N_MASTERS-1:0]        m_notify;
  logic [DATA_W-1:0]           s_out;
  logic                        s_out_sync;
  logic                        s_ready;
  logic [IDX_W-1:0]            grant_id;
  logic                        busy;
  logic                        err;

  modport master (
    input  m_data, m_sync, s_ready,
    output m_notify, s_out, s_out_sync, grant_id, busy, err
  );

  modport slave (
    output m_data, m_sync, s_ready,
    input  m_notify, s_out, s_out_sync, grant_id, busy, err
  );
endinterface

// File: rtl/ms_channel_arbiter_rr_pick.sv
// rtl/ms_channel_arbiter_rr_pick.sv - combinational round-robin selector (module ms_rr_pick)
//   req     in  N_MASTERS  request vector
//   last    in  IDX_W      index granted most recently
//   pick    out IDX_W      first requesting index scanning last+1 .. last, wrapping
//   any_req out 1          at least one request present
module ms_rr_pick #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W     = $clog2(N_MASTERS)
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     pick,
  output logic                 any_req
);

  int unsigned       pos;
  logic [IDX_W-1:0]  idx;

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is the one left standing. Offset N_MASTERS lands on 'last' itself,
  // making the previous winner the lowest priority.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    pos     = 0;
    idx     = '0;
    for (int off = N_MASTERS; off >= 1; off--) begin
      pos = (int'(last) + off) % N_MASTERS;
      idx = IDX_W'(pos);
      if (req[idx]) begin
        pick    = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ms_channel_arbiter.sv
// rtl/ms_channel_arbiter.sv - round-robin arbiter sharing one blocking master-slave channel
//   clk  in   clock
//   rst  in   asynchronous active-high reset
//   bus  master modport of ms_channel_arbiter_if (requests, downstream channel, status)
//   Optional feature: MS_ARB_TIMEOUT_EN adds an offer timeout (parameter TIMEOUT) and the err pulse.
module ms_channel_arbiter
  import ms_arbiter_types::*;
#(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32
`ifdef MS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 16
`endif
) (
  input logic                  clk,
  input logic                  rst,
  ms_channel_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(N_MASTERS);

  logic [1:0]           state_q, state_d;
  logic [DATA_W-1:0]    s_out_q, s_out_d;
  logic                 s_out_sync_q, s_out_sync_d;
  logic [N_MASTERS-1:0] m_notify_q, m_notify_d;
  logic [IDX_W-1:0]     grant_id_q, grant_id_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     pick;
  logic                 any_req;
`ifdef MS_ARB_TIMEOUT_EN
  logic [MS_ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  ms_rr_pick #(
    .N_MASTERS(N_MASTERS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req    (bus.m_sync),
    .last   (last_q),
    .pick   (pick),
    .any_req(any_req)
  );

  always_comb begin
    state_d      = state_q;
    s_out_d      = s_out_q;
    s_out_sync_d = s_out_sync_q;
    m_notify_d   = '0;
    grant_id_d   = grant_id_q;
    last_d       = last_q;
`ifdef MS_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          s_out_d      = bus.m_data[int'(pick)*DATA_W +: DATA_W];
          grant_id_d   = pick;
          last_d       = pick;
          s_out_sync_d = 1'b1;
          state_d      = ARB_OFFER;
`ifdef MS_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
        end
      end
      // Transfer is committed: payload and request inputs are not looked at here.
      ARB_OFFER: begin
        if (bus.s_ready) begin
          s_out_sync_d = 1'b0;
          m_notify_d   = N_MASTERS'(1) << grant_id_q;
          state_d      = ARB_DONE;
        end
`ifdef MS_ARB_TIMEOUT_EN
        // Abort keeps last=pick, so the stalled master drops to lowest priority.
        else if (cnt_q == MS_ARB_CNT_W'(TIMEOUT - 1)) begin
          s_out_sync_d = 1'b0;
          err_d        = 1'b1;
          state_d      = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        s_out_sync_d = 1'b0;
        state_d      = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      s_out_q      <= '0;
      s_out_sync_q <= 1'b0;
      m_notify_q   <= '0;
      grant_id_q   <= '0;
      last_q       <= IDX_W'(N_MASTERS - 1);
    end else begin
      state_q      <= state_d;
      s_out_q      <= s_out_d;
      s_out_sync_q <= s_out_sync_d;
      m_notify_q   <= m_notify_d;
      grant_id_q   <= grant_id_d;
      last_q       <= last_d;
    end
  end

`ifdef MS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.s_out      = s_out_q;
  assign bus.s_out_sync = s_out_sync_q;
  assign bus.m_notify   = m_notify_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = (state_q != ARB_IDLE);

endmodule
